// File: rtl/return_stack_if.sv
// Push/pop request and stack status bundle for return_stack.
// RETURN_STACK_HWM_EN adds the High_Water status signal.
interface return_stack_if #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned DEPTH  = 32
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              Push;
    logic              Pop;
    logic [ADDR_W-1:0] Push_Addr;
    logic              Err_Clear;
    logic [ADDR_W-1:0] Ret_Add;
    logic [CNT_W-1:0]  Count;
    logic              Empty;
    logic              Full;
    logic              Err_Out;
    logic [1:0]        Err_Code;
`ifdef RETURN_STACK_HWM_EN
    logic [CNT_W-1:0]  High_Water;
`endif

    modport master (
        output Push, Pop, Push_Addr, Err_Clear,
`ifdef RETURN_STACK_HWM_EN
        input  High_Water,
`endif
        input  Ret_Add, Count, Empty, Full, Err_Out, Err_Code
    );

    modport slave (
        input  Push, Pop, Push_Addr, Err_Clear,
`ifdef RETURN_STACK_HWM_EN
        output High_Water,
`endif
        output Ret_Add, Count, Empty, Full, Err_Out, Err_Code
    );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address stack with sticky overflow/underflow flags.
// Optional macro RETURN_STACK_HWM_EN adds a High_Water (max Count) output.
module return_stack #(
    parameter int unsigned ADDR_W   = 13,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned OVF_MODE = 0
) (
    input  logic          Slow_Clock,
    input  logic          Reset,
    return_stack_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_top;
    logic [CNT_W-1:0]  r_count;
    logic [1:0]        r_err;

    logic              w_empty;
    logic              w_full;
    logic              w_write;
    logic [PTR_W-1:0]  w_wr_idx;
    logic [PTR_W-1:0]  w_top_nxt;
    logic [CNT_W-1:0]  w_count_nxt;
    logic [1:0]        w_err_new;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // r_top always addresses the current top; a push lands one slot above it,
    // so a full circular stack naturally overwrites the oldest entry.
    always_comb begin
        w_write     = 1'b0;
        w_wr_idx    = r_top;
        w_top_nxt   = r_top;
        w_count_nxt = r_count;
        w_err_new   = '0;
        if (bus.Push && bus.Pop && !w_empty) begin
            w_write  = 1'b1;
            w_wr_idx = r_top;
        end else if (bus.Push) begin
            if (bus.Pop) begin
                w_err_new[1] = 1'b1;
            end
            if (!w_full) begin
                w_write     = 1'b1;
                w_wr_idx    = r_top + PTR_W'(1);
                w_top_nxt   = r_top + PTR_W'(1);
                w_count_nxt = r_count + CNT_W'(1);
            end else begin
                w_err_new[0] = 1'b1;
                if (OVF_MODE == 1) begin
                    w_write   = 1'b1;
                    w_wr_idx  = r_top + PTR_W'(1);
                    w_top_nxt = r_top + PTR_W'(1);
                end
            end
        end else if (bus.Pop) begin
            if (w_empty) begin
                w_err_new[1] = 1'b1;
            end else begin
                w_top_nxt   = r_top - PTR_W'(1);
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge Slow_Clock or negedge Reset) begin
        if (!Reset) begin
            r_top   <= '0;
            r_count <= '0;
            r_err   <= '0;
        end else begin
            r_top   <= w_top_nxt;
            r_count <= w_count_nxt;
            r_err   <= (bus.Err_Clear ? 2'b00 : r_err) | w_err_new;
        end
    end

    // Entries are only readable once written after reset, so no clear is needed.
    always_ff @(posedge Slow_Clock) begin
        if (w_write && Reset) begin
            r_mem[w_wr_idx] <= bus.Push_Addr;
        end
    end

`ifdef RETURN_STACK_HWM_EN
    logic [CNT_W-1:0] r_hwm;

    always_ff @(posedge Slow_Clock or negedge Reset) begin
        if (!Reset) begin
            r_hwm <= '0;
        end else if (w_count_nxt > r_hwm) begin
            r_hwm <= w_count_nxt;
        end
    end

    assign bus.High_Water = r_hwm;
`endif

    assign bus.Ret_Add  = w_empty ? '0 : r_mem[r_top];
    assign bus.Count    = r_count;
    assign bus.Empty    = w_empty;
    assign bus.Full     = w_full;
    assign bus.Err_Code = r_err;
    assign bus.Err_Out  = |r_err;
endmodule
